mem_port_arbiter: RTL and testbench

//   Shares one single-port instruction/data memory between the fetch unit (read-only)
//   and the load/store path of the execute stage. One transaction is in flight at a time.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MEM_LATENCY     = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [2:0]          LAT_INIT   = 3'(MEM_LATENCY);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state;
    logic [2:0]          lat_cnt;
    logic                owner_d;   // 1 = outstanding access belongs to the data port
    logic                we_q;      // outstanding access is a store
    logic [STREAK_W-1:0] streak;

    logic resp_cycle;
    logic can_issue;
    logic data_win;
    logic fetch_win;
    logic issue;

    // Arbitration: data first, fetch forced once data has won MAX contested grants in a row
    always_comb begin
        resp_cycle = (state == WAIT) && (lat_cnt == 3'd1);
        can_issue  = reset_n && ((state == IDLE) || resp_cycle);
        data_win   = can_issue && d_req && (!if_req || (streak != STREAK_MAX));
        fetch_win  = can_issue && if_req && !data_win;
        issue      = data_win || fetch_win;
    end

    // Grant and memory command are driven in the issue cycle from the winner's inputs
    always_comb begin
        if_gnt    = fetch_win;
        d_gnt     = data_win;
        mem_en    = issue;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (data_win) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_we ? d_wdata : '0;
            mem_wstrb = d_we ? d_wstrb : {STRB_W{1'b0}};
        end else if (fetch_win) begin
            mem_addr  = if_addr;
        end
    end

    // Response routing: only the owner sees rvalid/rdata; stores return zero data
    always_comb begin
        if_rvalid = reset_n && resp_cycle && !owner_d;
        d_rvalid  = reset_n && resp_cycle && owner_d;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !we_q) ? mem_rdata : '0;
        busy      = reset_n && (state == WAIT);
    end

    // Transaction FSM: one access in flight, new issue allowed in the response cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            lat_cnt <= 3'd0;
            owner_d <= 1'b0;
            we_q    <= 1'b0;
        end else if (issue) begin
            state   <= WAIT;
            lat_cnt <= LAT_INIT;
            owner_d <= data_win;
            we_q    <= data_win && d_we;
        end else if (state == WAIT) begin
            if (lat_cnt == 3'd1) begin
                state <= IDLE;
            end
            lat_cnt <= lat_cnt - 3'd1;
        end
    end

    // Streak counter: counts contested data wins, cleared whenever fetch is served
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak <= '0;
        end else if (fetch_win) begin
            streak <= '0;
        end else if (data_win && if_req && (streak != STREAK_MAX)) begin
            streak <= streak + STREAK_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter at latency 1 and 3
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wstrb = '0;

    logic        if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_en_1, mem_we_1, busy_1;
    logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic [3:0]  mem_wstrb_1;
    logic        if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3, mem_we_3, busy_3;
    logic [31:0] if_rdata_3, d_rdata_3, mem_addr_3, mem_wdata_3, mem_rdata_3;
    logic [3:0]  mem_wstrb_3;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] q1[$];
    logic [32:0] q3[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(1), .MAX_DATA_STREAK(4)) u_l1 (
        .clk(clk), .reset_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1), .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
        .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_wstrb(mem_wstrb_1), .mem_rdata(mem_rdata_1), .busy(busy_1)
    );

    mem_port_arbiter #(.MEM_LATENCY(3), .MAX_DATA_STREAK(4)) u_l3 (
        .clk(clk), .reset_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3), .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_wstrb(mem_wstrb_3), .mem_rdata(mem_rdata_3), .busy(busy_3)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory models: return mem_f(addr) exactly MEM_LATENCY cycles after mem_en
    logic [31:0] p3 [3];
    always @(posedge clk) begin
        mem_rdata_1 <= mem_en_1 ? mem_f(mem_addr_1) : 32'h0;
        p3[0] <= mem_en_3 ? mem_f(mem_addr_3) : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_rdata_3 = p3[2];

    // Scoreboard for latency-1 instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_rvalid_1 || d_rvalid_1) begin
                n_cmp++;
                if (q1.size() == 0 || (if_rvalid_1 && d_rvalid_1)) begin
                    n_err++;
                    $display("FAIL sb1_rvalid: if_rvalid=%0b d_rvalid=%0b queued=%0d, required one rvalid with a pending grant", if_rvalid_1, d_rvalid_1, q1.size());
                end else begin
                    logic [32:0] e, g;
                    e = q1.pop_front();
                    g = {d_rvalid_1, d_rvalid_1 ? d_rdata_1 : if_rdata_1};
                    if (g !== e) begin
                        n_err++;
                        $display("FAIL sb1_resp: got port_d=%0b data=%h, required port_d=%0b data=%h", g[32], g[31:0], e[32], e[31:0]);
                    end
                end
            end
            n_cmp++;
            if ((!if_rvalid_1 && if_rdata_1 !== 32'h0) || (!d_rvalid_1 && d_rdata_1 !== 32'h0) || (if_gnt_1 && d_gnt_1)) begin
                n_err++;
                $display("FAIL sb1_idle: if_rdata=%h d_rdata=%h gnts=%0b%0b, required 0 rdata without rvalid and one gnt", if_rdata_1, d_rdata_1, if_gnt_1, d_gnt_1);
            end
            if (d_gnt_1) q1.push_back({1'b1, d_we ? 32'h0 : mem_f(d_addr)});
            else if (if_gnt_1) q1.push_back({1'b0, mem_f(if_addr)});
        end
    end

    // Scoreboard for latency-3 instance
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_rvalid_3 || d_rvalid_3) begin
                n_cmp++;
                if (q3.size() == 0 || (if_rvalid_3 && d_rvalid_3)) begin
                    n_err++;
                    $display("FAIL sb3_rvalid: if_rvalid=%0b d_rvalid=%0b queued=%0d, required one rvalid with a pending grant", if_rvalid_3, d_rvalid_3, q3.size());
                end else begin
                    logic [32:0] e, g;
                    e = q3.pop_front();
                    g = {d_rvalid_3, d_rvalid_3 ? d_rdata_3 : if_rdata_3};
                    if (g !== e) begin
                        n_err++;
                        $display("FAIL sb3_resp: got port_d=%0b data=%h, required port_d=%0b data=%h", g[32], g[31:0], e[32], e[31:0]);
                    end
                end
            end
            n_cmp++;
            if ((!if_rvalid_3 && if_rdata_3 !== 32'h0) || (!d_rvalid_3 && d_rdata_3 !== 32'h0) || (if_gnt_3 && d_gnt_3)) begin
                n_err++;
                $display("FAIL sb3_idle: if_rdata=%h d_rdata=%h gnts=%0b%0b, required 0 rdata without rvalid and one gnt", if_rdata_3, d_rdata_3, if_gnt_3, d_gnt_3);
            end
            if (d_gnt_3) q3.push_back({1'b1, d_we ? 32'h0 : mem_f(d_addr)});
            else if (if_gnt_3) q3.push_back({1'b0, mem_f(if_addr)});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic test_drain(input string name);
        idle(6);
        n_cmp++;
        if (q1.size() != 0 || q3.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: pending l1=%0d l3=%0d, required 0/0", name, q1.size(), q3.size());
        end
    endtask

    task automatic test_reset();
        logic [31:0] any_out;
        rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; if_addr = 32'h10; d_addr = 32'h200; d_we = 1'b0;
        repeat (2) @(negedge clk);
        any_out = {if_gnt_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_en_1, mem_we_1, busy_1,
                   if_gnt_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_en_3, mem_we_3, busy_3, 18'h0}
                | if_rdata_1 | d_rdata_1 | mem_addr_1 | mem_wdata_1 | {28'h0, mem_wstrb_1}
                | if_rdata_3 | d_rdata_3 | mem_addr_3 | mem_wdata_3 | {28'h0, mem_wstrb_3};
        n_cmp++;
        if (any_out !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: or of outputs=%h, required 0", any_out);
        end
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_gnt_1 !== 1'b1 || if_gnt_1 !== 1'b0 || mem_addr_1 !== 32'h200) begin
            n_err++;
            $display("FAIL reset_first_gnt: d_gnt=%0b if_gnt=%0b mem_addr=%h, required 1 0 00000200", d_gnt_1, if_gnt_1, mem_addr_1);
        end
        cyc();
        if_req = 1'b0; d_req = 1'b0;
        test_drain("reset");
    endtask

    task automatic test_fetch_stream();
        if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_addr = 32'(i * 4);
            @(negedge clk);
            n_cmp++;
            if (if_gnt_1 !== 1'b1 || mem_addr_1 !== 32'(i * 4) || (i > 0 && if_rvalid_1 !== 1'b1)) begin
                n_err++;
                $display("FAIL fetch_stream_%0d: if_gnt=%0b mem_addr=%h if_rvalid=%0b, required 1 %h %0b", i, if_gnt_1, mem_addr_1, if_rvalid_1, 32'(i * 4), i > 0);
            end
            cyc();
        end
        if_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if_rvalid_1 !== 1'b1 || if_gnt_1 !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_stream_tail: if_rvalid=%0b if_gnt=%0b, required 1 0", if_rvalid_1, if_gnt_1);
        end
        cyc();
        test_drain("fetch_stream");
    endtask

    task automatic test_latency3();
        d_we = 1'b0; d_addr = 32'h100; d_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_gnt_3 !== 1'b1 || busy_3 !== 1'b0) begin
            n_err++;
            $display("FAIL lat3_gnt: d_gnt=%0b busy=%0b, required 1 0", d_gnt_3, busy_3);
        end
        cyc();
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h300;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (d_rvalid_3 !== (k == 3) || if_gnt_3 !== (k == 3) || busy_3 !== 1'b1 || (k == 3 && mem_addr_3 !== 32'h300)) begin
                n_err++;
                $display("FAIL lat3_T+%0d: d_rvalid=%0b if_gnt=%0b busy=%0b mem_addr=%h, required %0b %0b 1 (300 at T+3)", k, d_rvalid_3, if_gnt_3, busy_3, mem_addr_3, k == 3, k == 3);
            end
            cyc();
        end
        if_req = 1'b0;
        test_drain("lat3");
    endtask

    task automatic test_streak();
        rst_n = 1'b0;
        q1.delete(); q3.delete();
        cyc();
        rst_n = 1'b1;
        if_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0; if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic exp_d;
            exp_d = (i % 5) != 4;
            @(negedge clk);
            n_cmp++;
            if (d_gnt_1 !== exp_d || if_gnt_1 !== !exp_d) begin
                n_err++;
                $display("FAIL streak_%0d: d_gnt=%0b if_gnt=%0b, required %0b %0b", i, d_gnt_1, if_gnt_1, exp_d, !exp_d);
            end
            cyc();
        end
        if_req = 1'b0; d_req = 1'b0;
        test_drain("streak");
    endtask

    task automatic test_store();
        d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011; d_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_gnt_1 !== 1'b1 || mem_en_1 !== 1'b1 || mem_we_1 !== 1'b1 || mem_wstrb_1 !== 4'b0011 ||
            mem_wdata_1 !== 32'hDEADBEEF || mem_addr_1 !== 32'h40) begin
            n_err++;
            $display("FAIL store_issue: gnt=%0b en=%0b we=%0b wstrb=%b wdata=%h addr=%h, required 1 1 1 0011 deadbeef 00000040", d_gnt_1, mem_en_1, mem_we_1, mem_wstrb_1, mem_wdata_1, mem_addr_1);
        end
        cyc();
        d_addr = 32'h44; d_wstrb = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (d_rvalid_1 !== 1'b1 || d_rdata_1 !== 32'h0) begin
            n_err++;
            $display("FAIL store_ack: d_rvalid=%0b d_rdata=%h, required 1 00000000", d_rvalid_1, d_rdata_1);
        end
        n_cmp++;
        if (d_gnt_1 !== 1'b1 || mem_we_1 !== 1'b1 || mem_wstrb_1 !== 4'b0000) begin
            n_err++;
            $display("FAIL store_zero_strb: gnt=%0b we=%0b wstrb=%b, required 1 1 0000", d_gnt_1, mem_we_1, mem_wstrb_1);
        end
        cyc();
        d_req = 1'b0; d_we = 1'b0;
        test_drain("store");
    endtask

    task automatic test_reset_wait();
        d_we = 1'b0; d_addr = 32'h80; d_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_gnt_3 !== 1'b1) begin
            n_err++;
            $display("FAIL rstwait_gnt: d_gnt=%0b, required 1", d_gnt_3);
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if (busy_3 !== 1'b1) begin
            n_err++;
            $display("FAIL rstwait_busy: busy=%0b, required 1", busy_3);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy_3 !== 1'b0 || d_gnt_3 !== 1'b0 || mem_en_3 !== 1'b0 || d_rvalid_3 !== 1'b0) begin
            n_err++;
            $display("FAIL rstwait_async: busy=%0b d_gnt=%0b mem_en=%0b d_rvalid=%0b, required 0 0 0 0", busy_3, d_gnt_3, mem_en_3, d_rvalid_3);
        end
        q1.delete(); q3.delete();
        d_req = 1'b0;
        idle(2);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (d_rvalid_3 !== 1'b0 || if_rvalid_3 !== 1'b0) begin
                n_err++;
                $display("FAIL rstwait_dropped_%0d: d_rvalid=%0b if_rvalid=%0b, required 0 0", k, d_rvalid_3, if_rvalid_3);
            end
            cyc();
        end
        d_addr = 32'h90; d_req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (d_gnt_3 !== 1'b1 || busy_3 !== 1'b0 || mem_addr_3 !== 32'h90) begin
            n_err++;
            $display("FAIL rstwait_regrant: d_gnt=%0b busy=%0b mem_addr=%h, required 1 0 00000090", d_gnt_3, busy_3, mem_addr_3);
        end
        cyc();
        d_req = 1'b0;
        test_drain("rstwait");
    endtask

    initial begin
        test_reset();
        test_fetch_stream();
        test_latency3();
        test_streak();
        test_store();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
